// File: rtl/spi_slv.sv
// spi_slv: mode-3 SPI slave for BITS-wide frames, every pin oversampled on clk.
// Define SPI_SLV_FRM_ERR_EN to add a sticky frm_err output for malformed frames.
module spi_slv #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            SCLK,
  input  logic            MOSI,
  output logic            MISO,
  input  logic [BITS-1:0] tx_data,
  input  logic            wrt,
  output logic [BITS-1:0] cmd,
  output logic            rdy,
`ifdef SPI_SLV_FRM_ERR_EN
  output logic            frm_err,
`endif
  input  logic            clr_rdy
);

  localparam int unsigned CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] CntFull = CW'(BITS);
  localparam logic [CW-1:0] CntSat  = CW'(BITS + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Synchroniser chains: bit 0 is ff1, bit 2 is ff3.
  logic [2:0] r_sclk_ff, r_ss_ff, r_mosi_ff;

  state_e          r_state, w_state_d;
  logic [BITS-1:0] r_shft_reg, w_shft_d;
  logic [CW-1:0]   r_bit_cnt, w_cnt_d;
  logic            r_mosi_smpl, w_smpl_d;
  logic [BITS-1:0] r_cmd, w_cmd_d;
  logic            r_rdy, w_rdy_set;

  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_ff <= '1;
      r_ss_ff   <= '1;
      r_mosi_ff <= '0;
    end else begin
      r_sclk_ff <= {r_sclk_ff[1:0], SCLK};
      r_ss_ff   <= {r_ss_ff[1:0], SS_n};
      r_mosi_ff <= {r_mosi_ff[1:0], MOSI};
    end
  end

  assign w_sclk_rise =  r_sclk_ff[1] & ~r_sclk_ff[2];
  assign w_sclk_fall = ~r_sclk_ff[1] &  r_sclk_ff[2];
  assign w_ss_fall   = ~r_ss_ff[1]   &  r_ss_ff[2];
  assign w_ss_rise   =  r_ss_ff[1]   & ~r_ss_ff[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_shft_reg  <= '0;
      r_bit_cnt   <= '0;
      r_mosi_smpl <= 1'b0;
      r_cmd       <= '0;
      r_rdy       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shft_reg  <= w_shft_d;
      r_bit_cnt   <= w_cnt_d;
      r_mosi_smpl <= w_smpl_d;
      r_cmd       <= w_cmd_d;
      if (w_rdy_set) begin
        r_rdy <= 1'b1;
      end else if (clr_rdy || w_ss_fall) begin
        r_rdy <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shft_d  = r_shft_reg;
    w_cnt_d   = r_bit_cnt;
    w_smpl_d  = r_mosi_smpl;
    w_cmd_d   = r_cmd;
    w_rdy_set = 1'b0;
    case (r_state)
      StIdle: begin
        if (wrt) begin
          w_shft_d = tx_data;
        end
        if (w_ss_fall) begin
          w_state_d = StShift;
          w_cnt_d   = '0;
        end
      end
      StShift: begin
        if (w_sclk_rise) begin
          w_smpl_d = r_mosi_ff[2];
          if (r_bit_cnt != CntSat) begin
            w_cnt_d = r_bit_cnt + 1'b1;
          end
        end
        // The leading fall of a frame must not shift: the MSB is already on MISO.
        if (w_sclk_fall && (r_bit_cnt != '0)) begin
          w_shft_d = {r_shft_reg[BITS-2:0], r_mosi_smpl};
        end
        if (w_ss_rise) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        // The final bit has no trailing fall, so it is merged here.
        if (r_bit_cnt == CntFull) begin
          w_cmd_d   = {r_shft_reg[BITS-2:0], r_mosi_smpl};
          w_rdy_set = 1'b1;
        end
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign MISO = ((r_state != StIdle) || !SS_n) ? r_shft_reg[BITS-1] : 1'b0;
  assign cmd  = r_cmd;
  assign rdy  = r_rdy;

`ifdef SPI_SLV_FRM_ERR_EN
  logic r_frm_err;
  logic w_frm_set;

  // Bad length at frame end, or any SCLK edge while deselected.
  assign w_frm_set = ((r_state == StDone) && (r_bit_cnt != CntFull)) ||
                     ((w_sclk_rise || w_sclk_fall) && r_ss_ff[1] && r_ss_ff[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm_err <= 1'b0;
    end else if (w_frm_set) begin
      r_frm_err <= 1'b1;
    end else if (clr_rdy) begin
      r_frm_err <= 1'b0;
    end
  end

  assign frm_err = r_frm_err;
`endif

endmodule

// File: tb/tb_spi_slv.sv
// tb_spi_slv: drives mode-3 SPI frames at SCLK = clk/32 into spi_slv and scores
// the words read back on MISO plus the cmd/rdy results.
module tb_spi_slv;

  localparam int unsigned BITS = 16;
  localparam int HALF = 16;

  logic            clk = 1'b0;
  logic            rst, SS_n, SCLK, MOSI, MISO, wrt, clr_rdy, rdy;
  logic [BITS-1:0] tx_data, cmd;
`ifdef SPI_SLV_FRM_ERR_EN
  logic            frm_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_slv #(.BITS(BITS)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .rdy     (rdy),
`ifdef SPI_SLV_FRM_ERR_EN
    .frm_err (frm_err),
`endif
    .clr_rdy (clr_rdy)
  );

  typedef struct {
    bit              do_wrt;
    logic [BITS-1:0] tx;
    logic [BITS-1:0] mosi;
    int              nbits;
    logic [BITS-1:0] exp_miso;
    logic [BITS-1:0] exp_cmd;
    logic            exp_rdy;
  } vec_t;

  typedef struct {
    logic [BITS-1:0] miso;
    logic [BITS-1:0] cmd;
    logic            rdy;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [BITS-1:0] word);
    tx_data = word;
    wrt     = 1'b1;
    tick(1);
    wrt     = 1'b0;
    tick(2);
  endtask

  // Master side: MOSI changes on SCLK fall, MISO captured just before SCLK rise.
  task automatic run_frame(input logic [BITS-1:0] mosi_word, input int nbits,
                           input bit wrt_mid, output logic [BITS-1:0] rd);
    rd   = '0;
    SS_n = 1'b0;
    tick(8);
    check("rdy_clear_on_ss_fall", rdy, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mosi_word[BITS-1-i];
      if (wrt_mid && i == 4) begin
        tx_data = 16'h0F0F;
        wrt     = 1'b1;
        tick(1);
        wrt     = 1'b0;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      rd   = {rd[BITS-2:0], MISO};
      SCLK = 1'b1;
      tick(HALF);
    end
    tick(4);
    SS_n = 1'b1;
  endtask

  // Bounded: result must be visible within 4 clk of SS_n rise.
  task automatic wait_done();
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (rdy === 1'b1) break;
    end
  endtask

  initial begin
    logic [BITS-1:0] rd;
    exp_t            e;

    vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 16, 16'hA5C3, 16'h1234, 1'b1};
    vecs[1] = '{1'b1, 16'hF00E, 16'hFFFF, 16, 16'hF00E, 16'hFFFF, 1'b1};
    vecs[2] = '{1'b0, 16'h0000, 16'h0001, 16, 16'h7FFF, 16'h0001, 1'b1};
    vecs[3] = '{1'b1, 16'h1111, 16'hABCD, 9,  16'h1111, 16'h0001, 1'b0};

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; clr_rdy = 1'b0; tx_data = '0;
    tick(3);
    rst = 1'b0;
    tick(4);
    check("reset_miso", MISO, 1'b0);
    check("reset_rdy", rdy, 1'b0);
    check("reset_cmd", cmd, 16'h0000);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_wrt) load(vecs[v].tx);
      sb.push_back('{vecs[v].exp_miso >> (BITS - vecs[v].nbits), vecs[v].exp_cmd,
                     vecs[v].exp_rdy});
      run_frame(vecs[v].mosi, vecs[v].nbits, 1'b0, rd);
      wait_done();
      e = sb.pop_front();
      check($sformatf("vec%0d_miso", v), rd, e.miso);
      check($sformatf("vec%0d_cmd", v), cmd, e.cmd);
      check($sformatf("vec%0d_rdy", v), rdy, e.rdy);
      tick(6);
    end
`ifdef SPI_SLV_FRM_ERR_EN
    check("short_frame_frm_err", frm_err, 1'b1);
`endif

    // Re-run a good frame, then clear rdy explicitly.
    load(16'h2468);
    run_frame(16'h55AA, 16, 1'b0, rd);
    wait_done();
    check("rerun_cmd", cmd, 16'h55AA);
    check("rerun_miso", rd, 16'h2468);
    tick(4);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    check("clr_rdy", rdy, 1'b0);
`ifdef SPI_SLV_FRM_ERR_EN
    check("clr_frm_err", frm_err, 1'b0);
`endif

    // Reset mid-frame after 5 bits, then a clean frame.
    load(16'h5A5A);
    SS_n = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = i[0];
      tick(HALF);
      SCLK = 1'b1;
      tick(HALF);
    end
    SS_n = 1'b1;
    rst  = 1'b1;
    tick(2);
    rst  = 1'b0;
    tick(4);
    check("midrst_cmd", cmd, 16'h0000);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_miso", MISO, 1'b0);
    load(16'hC001);
    sb.push_back('{16'hC001, 16'hBEEF, 1'b1});
    run_frame(16'hBEEF, 16, 1'b0, rd);
    wait_done();
    e = sb.pop_front();
    check("after_rst_miso", rd, e.miso);
    check("after_rst_cmd", cmd, e.cmd);
    check("after_rst_rdy", rdy, e.rdy);
    tick(6);

    // wrt during SHIFT must not disturb the word being shifted out.
    load(16'h96E1);
    sb.push_back('{16'h96E1, 16'h3C5A, 1'b1});
    run_frame(16'h3C5A, 16, 1'b1, rd);
    wait_done();
    e = sb.pop_front();
    check("wrt_in_shift_miso", rd, e.miso);
    check("wrt_in_shift_cmd", cmd, e.cmd);
    check("wrt_in_shift_rdy", rdy, e.rdy);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slv.md
Name: spi_slv

Overview:
- SPI slave (responder) for 16-bit packets, mode 3: SCLK idles high, MOSI sampled on SCLK rise, MISO launched on SCLK fall, SS_n active low.
- Sits on the peripheral side of the system SPI bus and runs entirely on the system clock.
- All SPI inputs are oversampled. SCLK is expected at 1/32 of clk or slower.
- Delivers the received command word with a sticky ready flag. Returns a locally loaded response word on MISO in the same frame.

Parameters:
- BITS, 16: bits per frame. Bit counter width is $clog2(BITS)+1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- SS_n  in  1  slave select, active low, asynchronous to clk.
- SCLK  in  1  serial clock from master, asynchronous.
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial data to master, MSB first.
- tx_data  in  BITS  response word for the next frame.
- wrt  in  1  load tx_data into the shift register; honoured only in IDLE.
- cmd  out  BITS  last complete word received.
- rdy  out  1  sticky: a new cmd is available.
- clr_rdy  in  1  clears rdy.

Behaviour:
- Synchronisation:
  - SCLK, MOSI and SS_n each pass through 3 flops (ff1..ff3).
  - sclk_rise = ff2&~ff3; sclk_fall = ~ff2&ff3; ss_fall = ~ff2&ff3; ss_rise = ff2&~ff3.
  - MOSI is sampled from mosi_ff3, the value aligned with sclk_ff3, i.e. the data valid before the edge.
  - Latency from pin to action is 2-3 clk.
- Reset (rst=1 at posedge):
  - state=IDLE, shft_reg=0, bit_cnt=0, mosi_smpl=0, cmd=0, rdy=0.
  - Synchroniser flops: SCLK and SS_n reset to 1, MOSI resets to 0.
  - Reset mid-frame abandons the frame. No rdy is produced.
- MISO = shft_reg[BITS-1] whenever state!=IDLE or SS_n is low; otherwise MISO=0.
- State IDLE:
  - wrt loads shft_reg<=tx_data.
  - ss_fall goes to SHIFT with bit_cnt<=0.
  - If wrt and ss_fall occur in the same cycle, the load happens and SHIFT is entered.
- State SHIFT:
  - On sclk_rise: mosi_smpl<=mosi_ff3 and bit_cnt<=bit_cnt+1.
  - On sclk_fall, only when bit_cnt>0: shft_reg<={shft_reg[BITS-2:0],mosi_smpl}, which exposes the next MISO bit.
  - The first fall after ss_fall (bit_cnt==0) does not shift, so the MSB stays on MISO until the first rise.
  - wrt is ignored in this state.
  - On ss_rise go to DONE.
- State DONE, one cycle:
  - If bit_cnt==BITS: cmd<={shft_reg[BITS-2:0],mosi_smpl}, rdy<=1. This completes the last bit, which has no trailing fall.
  - Otherwise the frame is short or long: cmd and rdy are unchanged.
  - Always return to IDLE. shft_reg keeps its value until the next wrt.
- rdy:
  - Set in DONE.
  - Cleared by clr_rdy, or by ss_fall of the next frame.
  - If the set and a clear occur in the same cycle, set wins.
- Extra SCLK edges beyond BITS: bit_cnt saturates at BITS+1 and shifting continues; the frame is discarded in DONE.
- Glitch-free operation requires SS_n to be stable for 2+ clk and SCLK high/low phases to be 3+ clk each.

Optional Feature:
- SPI_SLV_FRM_ERR_EN defined:
  - Adds output frm_err (1 bit, reset 0).
  - frm_err is set in DONE when bit_cnt!=BITS.
  - frm_err is also set on an sclk edge seen while SS_n is high.
  - Cleared by clr_rdy; set wins over clear.
- SPI_SLV_FRM_ERR_EN undefined: no port, and bad frames are silently dropped.

Test Plan:
- Reset, then IDLE -> MISO=0, rdy=0, cmd=16'h0000.
- wrt with tx_data=16'hA5C3, then master sends 16'h1234 at SCLK=clk/32 -> master reads 16'hA5C3; cmd=16'h1234 and rdy=1 within 4 clk of SS_n rise.
- Back-to-back frames 16'hFFFF then 16'h0001 without clr_rdy, no wrt before the 2nd -> rdy drops at the 2nd SS_n fall and rises at its end with cmd=16'h0001; MISO returns the final shifted contents from frame 1.
- Frame aborted after 9 SCLK rises -> cmd stays at its previous value, rdy=0; with SPI_SLV_FRM_ERR_EN, frm_err=1.
- rst asserted mid-frame after 5 bits, then a full frame 16'hBEEF -> cmd=16'hBEEF and rdy=1. No residue from the aborted frame.
- wrt pulsed during SHIFT with tx_data=16'h0F0F -> ignored; the in-flight MISO word is unchanged.
